// File: rtl/demux_pkg.sv
// Shared channel indices and select type for the buffered 1-to-4 stream router.
package demux_pkg;
  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_C   = 2;
  localparam int CH_D   = 3;
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;
endpackage

// File: rtl/demux_stream_buf_x4_chan_fifo2.sv
// Two-entry per-channel FIFO: 1-bit wrapping pointers, 0..2 occupancy count, head-data output.
module chan_fifo2 #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BUS_WIDTH-1:0] din,
  output logic                 full,
  output logic                 empty,
  output logic [BUS_WIDTH-1:0] head
);
  logic [1:0]           count_q, count_d;
  logic                 rd_q, wr_q;
  logic [BUS_WIDTH-1:0] mem_q [2];
  logic                 do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  // Guard locally so a stray push on full or pop on empty cannot corrupt state.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];

  always_comb begin
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
    end
  end
endmodule

// File: rtl/demux_stream_buf_x4.sv
// Buffered valid/ready 1-to-4 router: words steered by sel into per-channel 2-deep FIFOs.
module demux_stream_buf_x4
  import demux_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BUS_WIDTH-1:0]  y,
  input  ch_sel_t               sel,
  output logic [BUS_WIDTH-1:0]  a,
  output logic [BUS_WIDTH-1:0]  b,
  output logic [BUS_WIDTH-1:0]  c,
  output logic [BUS_WIDTH-1:0]  d,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic                  busy
);
  logic [NUM_CH-1:0]    full, empty, push, pop;
  logic [BUS_WIDTH-1:0] head [NUM_CH];

  // Ready depends only on the addressed FIFO's registered fill state, never on in_valid.
  assign in_ready = ~full[sel];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = in_valid & in_ready & (sel == ch_sel_t'(i));
    assign pop[i]  = ~empty[i] & out_ready[i];

    chan_fifo2 #(.BUS_WIDTH(BUS_WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (y),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  assign out_valid = ~empty;
  assign busy      = |out_valid;

  // Empty channels drive zero so stale storage is never visible.
  assign a = out_valid[CH_A] ? head[CH_A] : '0;
  assign b = out_valid[CH_B] ? head[CH_B] : '0;
  assign c = out_valid[CH_C] ? head[CH_C] : '0;
  assign d = out_valid[CH_D] ? head[CH_D] : '0;
endmodule

// File: tb/tb_demux_stream_buf_x4.sv
// Bench for demux_stream_buf_x4: per-channel queue model checked at every falling edge.
module tb_demux_stream_buf_x4;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic [1:0] sel;
  logic [7:0] a, b, c, d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [4][$];
  logic       stall_q = 1'b0;

  demux_stream_buf_x4 #(.BUS_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] chan_out(int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the queue model, then advance the model
  // with what the coming rising edge will do (decisions use the pre-edge state).
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      bit acc;
      logic [7:0] exp_d;
      for (int i = 0; i < 4; i++) begin
        exp_d = (mq[i].size() > 0) ? mq[i][0] : 8'h00;
        check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
        check($sformatf("data[%0d]", i), 32'(chan_out(i)), 32'(exp_d));
      end
      check("in_ready", 32'(in_ready), 32'(mq[sel].size() < 2));
      check("busy", 32'(busy),
            32'((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) > 0));
      acc = in_valid && (mq[sel].size() < 2);
      for (int i = 0; i < 4; i++)
        if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
      if (acc) mq[sel].push_back(y);
    end
  end

  task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] dat,
                     input logic [3:0] r);
    in_valid  = v;
    sel       = s;
    y         = dat;
    out_ready = r;
    #2;
    stall_q = in_valid & ~in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " abcd"}, {a, b, c, d}, 32'h0);
    check({tag, " in_ready"}, 32'(in_ready), 32'h1);
    check({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; y = 8'h00; sel = 2'd0; out_ready = 4'h0;
    #1;
    reset_check("rst0");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 8'h00, 4'h0);

    // Routing through all four channels with consumers always ready
    cyc(1, 0, 8'h11, 4'hF);
    cyc(1, 1, 8'h22, 4'hF);
    cyc(1, 2, 8'h33, 4'hF);
    cyc(1, 3, 8'h44, 4'hF);
    cyc(0, 0, 8'h00, 4'hF);
    cyc(0, 0, 8'h00, 4'hF);

    // Backpressure isolation on channel c
    cyc(1, 2, 8'hA1, 4'h0);
    cyc(1, 2, 8'hA2, 4'h0);
    cyc(0, 2, 8'h00, 4'h0);
    check("c_full in_ready", 32'(in_ready), 32'h0);
    cyc(1, 0, 8'hB0, 4'h0);
    cyc(0, 0, 8'h00, 4'h4);
    cyc(0, 0, 8'h00, 4'h4);
    cyc(0, 0, 8'h00, 4'h1);

    // Push and pop together at count 1 on channel b
    cyc(1, 1, 8'h5A, 4'h0);
    cyc(1, 1, 8'h6B, 4'h2);
    check("b_after_pp", 32'(b), 32'h6B);
    cyc(0, 1, 8'h00, 4'h0);
    cyc(0, 1, 8'h00, 4'h2);

    // Full channel d popping while C3 waits; no pass-through
    cyc(1, 3, 8'hC1, 4'h0);
    cyc(1, 3, 8'hC2, 4'h0);
    cyc(1, 3, 8'hC3, 4'h8);
    cyc(1, 3, 8'hC3, 4'h8);
    cyc(0, 3, 8'h00, 4'h8);
    cyc(0, 3, 8'h00, 4'h8);
    cyc(0, 3, 8'h00, 4'h0);

    // Mid-run reset with every channel holding data
    cyc(1, 0, 8'h01, 4'h0);
    cyc(1, 1, 8'h02, 4'h0);
    cyc(1, 2, 8'h03, 4'h0);
    cyc(1, 3, 8'h04, 4'h0);
    in_valid = 1'b0;
    check("pre_rst out_valid", 32'(out_valid), 32'hF);
    rst = 1'b1;
    #1;
    reset_check("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 8'h00, 4'h0);

    // Random stress honouring the hold-while-stalled upstream contract
    for (int n = 0; n < 10000; n++) begin
      logic       v;
      logic [1:0] s;
      logic [7:0] dat;
      logic [3:0] r;
      if (stall_q) begin
        v = in_valid; s = sel; dat = y;
      end else begin
        v   = ($urandom_range(0, 99) < 70);
        s   = 2'($urandom_range(0, 3));
        dat = 8'($urandom);
      end
      r = 4'($urandom);
      cyc(v, s, dat, r);
    end

    cyc(0, 0, 8'h00, 4'hF);
    cyc(0, 0, 8'h00, 4'hF);
    cyc(0, 0, 8'h00, 4'hF);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
